// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flexible FIFO: pointer sizing, pointer wrap, error-flag bit positions.
package sync_fifo_pkg;

    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_W         = 2;

    function automatic int ptr_width(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // Explicit compare so non-power-of-two depths wrap at depth-1.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer-facing bundle for sync_fifo_flex; master drives requests, slave is the FIFO.
interface sync_fifo_flex_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             clr_err;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             rd_en;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic [CW-1:0]    max_count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, clr_err, wr_en, wr_data, rd_en,
        input  wr_valid, rd_valid, rd_data, count, max_count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wr_en, wr_data, rd_en,
        output wr_valid, rd_valid, rd_data, count, max_count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ptr.sv
// FIFO ring pointer: increments on enable with wrap at DEPTH-1, synchronous clear.
// Latency: new value visible the cycle after inc_i; clear has priority over increment.
module sync_fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic          clock,
    input  logic          rstn,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)
            ptr_d = '0;
        else if (inc_i)
            ptr_d = PW'(ptr_next(int'(ptr_q), DEPTH));
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised show-ahead synchronous FIFO with registered count, margins, watermark and sticky errors.
// Latency: written word visible on rd_data one edge later; accept strobes are combinational.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 32,
    parameter int AF_MARGIN = 3,
    parameter int AE_MARGIN = 1
) (
    input  logic             clock,
    input  logic             rstn,
    sync_fifo_flex_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count_q, count_d, max_q, max_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             full, empty, wr_acc, rd_acc;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a pop.
    assign wr_acc = bus.wr_en & ~bus.flush & (~full | bus.rd_en);
    assign rd_acc = bus.rd_en & ~bus.flush & ~empty;

    sync_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_head (
        .clock (clock), .rstn (rstn), .clr_i (bus.flush), .inc_i (rd_acc), .ptr_o (head)
    );

    sync_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_tail (
        .clock (clock), .rstn (rstn), .clr_i (bus.flush), .inc_i (wr_acc), .ptr_o (tail)
    );

    always_ff @(posedge clock) begin
        if (wr_acc) mem_q[tail] <= bus.wr_data;
    end

    always_comb begin
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        max_d   = (count_d > max_q) ? count_d : max_q;
        err_d   = err_q;
        if (bus.clr_err)            err_d = '0;
        if (bus.wr_en && !wr_acc)   err_d[ERR_OVERFLOW]  = 1'b1;
        if (bus.rd_en && !rd_acc)   err_d[ERR_UNDERFLOW] = 1'b1;
        if (bus.flush) begin
            count_d = '0;
            max_d   = '0;
            err_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            max_q   <= '0;
            err_q   <= '0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            err_q   <= err_d;
        end
    end

    assign bus.wr_valid     = wr_acc;
    assign bus.rd_valid     = rd_acc;
    assign bus.rd_data      = empty ? '0 : mem_q[head];
    assign bus.count        = count_q;
    assign bus.max_count    = max_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(DEPTH - AF_MARGIN));
    assign bus.almost_empty = (count_q <= CW'(AE_MARGIN));
    assign bus.overflow     = err_q[ERR_OVERFLOW];
    assign bus.underflow    = err_q[ERR_UNDERFLOW];
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex at DEPTH=5, WIDTH=8, AF_MARGIN=1, AE_MARGIN=1.
module tb_sync_fifo_flex;
    logic clock = 1'b0;
    logic rstn  = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic       last_wv, last_rv;
    logic [7:0] last_rd;

    always #5 clock = ~clock;

    sync_fifo_flex_if #(.DEPTH(5), .WIDTH(8)) bus ();

    sync_fifo_flex #(.DEPTH(5), .WIDTH(8), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
        .clock (clock),
        .rstn  (rstn),
        .bus   (bus)
    );

    // Drives one cycle starting at posedge+1, samples strobes and head word mid-cycle, returns at posedge+1.
    task automatic do_cycle(input logic w, input logic [7:0] d, input logic r,
                            input logic f, input logic c);
        bus.wr_en = w; bus.wr_data = d; bus.rd_en = r; bus.flush = f; bus.clr_err = c;
        #2;
        last_wv = bus.wr_valid; last_rv = bus.rd_valid; last_rd = bus.rd_data;
        @(posedge clock); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic test_reset;
        bus.wr_en = 0; bus.wr_data = 0; bus.rd_en = 0; bus.flush = 0; bus.clr_err = 0;
        rstn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b/%b exp=1/1", bus.empty, bus.almost_empty); end
        checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b/%b exp=0/0", bus.full, bus.almost_full); end
        checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b/%b exp=0/0", bus.overflow, bus.underflow); end
        checks++; if (bus.rd_data !== 8'h00 || bus.max_count !== 3'd0) begin failures++; $display("FAIL reset_data got=%h/%0d exp=00/0", bus.rd_data, bus.max_count); end
        rstn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_fill;
        logic [7:0] d;
        for (int i = 1; i <= 5; i++) begin
            d = 8'h10 + 8'(i);
            do_cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
            checks++; if (last_wv !== 1'b1) begin failures++; $display("FAIL fill_wv%0d got=%b exp=1", i, last_wv); end
            checks++; if (bus.count !== 3'(i)) begin failures++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, bus.count, i); end
            checks++; if (bus.rd_data !== 8'h11) begin failures++; $display("FAIL fill_head%0d got=%h exp=11", i, bus.rd_data); end
            checks++; if (bus.almost_empty !== (i <= 1)) begin failures++; $display("FAIL fill_ae%0d got=%b exp=%b", i, bus.almost_empty, i <= 1); end
            checks++; if (bus.almost_full !== (i >= 4)) begin failures++; $display("FAIL fill_af%0d got=%b exp=%b", i, bus.almost_full, i >= 4); end
            checks++; if (bus.full !== (i == 5)) begin failures++; $display("FAIL fill_full%0d got=%b exp=%b", i, bus.full, i == 5); end
        end
        checks++; if (bus.max_count !== 3'd5) begin failures++; $display("FAIL fill_max got=%0d exp=5", bus.max_count); end
        do_cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checks++; if (last_wv !== 1'b0) begin failures++; $display("FAIL ovf_wv got=%b exp=0", last_wv); end
        checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd5) begin failures++; $display("FAIL ovf_flag got=%b/%0d exp=1/5", bus.overflow, bus.count); end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 5; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checks++; if (last_rv !== 1'b1 || last_rd !== 8'h10 + 8'(i)) begin failures++; $display("FAIL drain%0d got=%b/%h exp=1/%h", i, last_rv, last_rd, 8'h10 + 8'(i)); end
        end
        checks++; if (bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin failures++; $display("FAIL drain_empty got=%b/%h exp=1/00", bus.empty, bus.rd_data); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (last_rv !== 1'b0 || bus.underflow !== 1'b1) begin failures++; $display("FAIL unf got=%b/%b exp=0/1", last_rv, bus.underflow); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin failures++; $display("FAIL set_wins got=%b/%b exp=1/0", bus.underflow, bus.overflow); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int i = 0; i < 3; i++) begin
                d = 8'h20 + 8'(rnd * 3 + i);
                do_cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
            end
            checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL wrap_count r%0d got=%0d exp=3", rnd, bus.count); end
            for (int i = 0; i < 3; i++) begin
                d = 8'h20 + 8'(rnd * 3 + i);
                do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                checks++; if (last_rd !== d) begin failures++; $display("FAIL wrap_data r%0d i%0d got=%h exp=%h", rnd, i, last_rd, d); end
            end
        end
        checks++; if (bus.empty !== 1'b1 || bus.max_count !== 3'd5) begin failures++; $display("FAIL wrap_end got=%b/%0d exp=1/5", bus.empty, bus.max_count); end
    endtask

    task automatic test_simul;
        for (int i = 1; i <= 5; i++) do_cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        checks++; if (last_wv !== 1'b1 || last_rv !== 1'b1 || last_rd !== 8'h31) begin failures++; $display("FAIL full_both got=%b/%b/%h exp=1/1/31", last_wv, last_rv, last_rd); end
        checks++; if (bus.count !== 3'd5 || bus.overflow !== 1'b0) begin failures++; $display("FAIL full_both_count got=%0d/%b exp=5/0", bus.count, bus.overflow); end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checks++; if (last_rd !== ((i == 4) ? 8'h99 : 8'h32 + 8'(i))) begin failures++; $display("FAIL full_both_pop%0d got=%h", i, last_rd); end
        end
        do_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        checks++; if (last_wv !== 1'b1 || last_rv !== 1'b0) begin failures++; $display("FAIL empty_both got=%b/%b exp=1/0", last_wv, last_rv); end
        checks++; if (bus.count !== 3'd1 || bus.rd_data !== 8'h77 || bus.underflow !== 1'b1) begin failures++; $display("FAIL empty_both_state got=%0d/%h/%b exp=1/77/1", bus.count, bus.rd_data, bus.underflow); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_flush;
        for (int i = 1; i <= 5; i++) do_cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1 || bus.max_count !== 3'd5) begin failures++; $display("FAIL pre_flush got=%0d/%b/%0d exp=3/1/5", bus.count, bus.overflow, bus.max_count); end
        do_cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        checks++; if (last_wv !== 1'b0) begin failures++; $display("FAIL flush_wv got=%b exp=0", last_wv); end
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL flush_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
        checks++; if (bus.overflow !== 1'b0 || bus.max_count !== 3'd0 || bus.rd_data !== 8'h00) begin failures++; $display("FAIL flush_state got=%b/%0d/%h exp=0/0/00", bus.overflow, bus.max_count, bus.rd_data); end
        do_cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.rd_data !== 8'h66 || bus.count !== 3'd1) begin failures++; $display("FAIL post_flush got=%h/%0d exp=66/1", bus.rd_data, bus.count); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        do_cycle(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL mid_pre got=%0d exp=2", bus.count); end
        #2; rstn = 1'b0; #1;
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00 || bus.max_count !== 3'd0) begin failures++; $display("FAIL mid_reset got=%0d/%b/%h/%0d exp=0/1/00/0", bus.count, bus.empty, bus.rd_data, bus.max_count); end
        @(negedge clock); rstn = 1'b1;
        @(posedge clock); #1;
        do_cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (last_rd !== 8'h61 || bus.count !== 3'd1) begin failures++; $display("FAIL mid_first got=%h/%0d exp=61/1", last_rd, bus.count); end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_wrap;
        test_simul;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
